// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl
//   Run/pause/clear controller for a chain of cascaded BCD decade digits.
//   A prescaler turns clk into count ticks. A three-state FSM (IDLE, RUN,
//   PAUSED) gates those ticks onto the digit chain. The chain ripples decade
//   carries within one edge and flags wrap-around from all-9s.
//
// Optional feature:
//   BCD_SW_LAP_EN - when defined, builds a lap-hold register. A lap pulse in
//                   RUN/PAUSED toggles the hold. While the hold is set, digits
//                   shows the captured count and live counting continues.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   start/resume request (level, sampled each edge)
//   stop     in   pause request (level, sampled each edge)
//   clear    in   zero count and return to IDLE (highest priority)
//   lap      in   lap-hold toggle pulse (used only with BCD_SW_LAP_EN)
//   digits   out  BCD count, 4 bits per digit, digit 0 in [3:0]
//   running  out  high while the FSM is in RUN
//   tick     out  combinational one-cycle pulse on the cycle the count increments
//   overflow out  sticky wrap flag, cleared by clear or rst

module bcd_stopwatch_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  running,
    output logic                  tick,
    output logic                  overflow
);

    localparam int unsigned DW = 4 * DIGITS;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_nxt;
    logic [DW-1:0]   r_count;
    logic [DW-1:0]   w_count_nxt;
    logic            r_overflow;
    logic            w_overflow_nxt;
    logic            w_tick;
    logic            w_wrap;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: clear > stop > start. A stop outside RUN also swallows a
    // simultaneous start, so PAUSED is only left through a clean start.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else if (stop) begin
            if (r_state == S_RUN) begin
                w_state_nxt = S_PAUSED;
            end
        end else if (start) begin
            w_state_nxt = S_RUN;
        end
    end

    assign w_tick = (r_state == S_RUN) && (r_presc == PRESC_LAST);

    // Prescaler: advances only in RUN, so a pause keeps the partial period
    always_comb begin
        w_presc_nxt = r_presc;
        if (clear) begin
            w_presc_nxt = '0;
        end else if (r_state == S_RUN) begin
            w_presc_nxt = (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
        end
    end

    // Digit chain: a digit steps when the tick reaches it through all-9
    // digits below it. The carry out of the top digit is the wrap.
    always_comb begin : digit_chain
        logic v_carry;
        v_carry     = w_tick;
        w_count_nxt = r_count;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v_carry) begin
                w_count_nxt[4*i +: 4] = (r_count[4*i +: 4] == 4'd9) ? 4'd0
                                        : r_count[4*i +: 4] + 4'd1;
            end
            v_carry = v_carry && (r_count[4*i +: 4] == 4'd9);
        end
        w_wrap = v_carry;
        if (clear) begin
            w_count_nxt = '0;
        end
    end

    // Sticky overflow
    always_comb begin
        w_overflow_nxt = r_overflow;
        if (clear) begin
            w_overflow_nxt = 1'b0;
        end else if (w_wrap) begin
            w_overflow_nxt = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_presc    <= w_presc_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

`ifdef BCD_SW_LAP_EN
    logic            r_hold;
    logic [DW-1:0]   r_lap;

    // Lap hold: setting the hold captures the live count. Releasing it leaves
    // r_lap stale, but r_lap is only shown while the hold is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= 1'b0;
            r_lap  <= '0;
        end else if (clear) begin
            r_hold <= 1'b0;
        end else if (lap && (r_state != S_IDLE)) begin
            r_hold <= ~r_hold;
            if (!r_hold) begin
                r_lap <= r_count;
            end
        end
    end

    assign digits = r_hold ? r_lap : r_count;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign digits       = r_count;
`endif

    assign running  = (r_state == S_RUN);
    assign tick     = w_tick;
    assign overflow = r_overflow;

endmodule
